// File: rtl/lock_pkg.sv
// Shared definitions for the time-keyed lock blocks: FSM state encoding,
// default bank geometry and the phase-to-window decode used by every
// block that must stay phase-aligned with the key sequencer.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int DEFAULT_KEY_W    = 10;
    localparam int DEFAULT_NUM_KEYS = 3;
    localparam int DEFAULT_WINDOW   = 6;
    localparam int DEFAULT_PH_W     = 6;
    localparam int PERIOD           = DEFAULT_NUM_KEYS * DEFAULT_WINDOW;

    // Window index by range compare, so no divider is built. The loop bound
    // is fixed at 4 because the window index is two bits wide.
    function automatic logic [1:0] phase_to_win(input int unsigned ph,
                                                input int unsigned window,
                                                input int unsigned num_keys);
        logic [1:0] w;
        w = 2'd0;
        for (int unsigned k = 1; k < 4; k++) begin
            if (k < num_keys && ph >= k * window) begin
                w = 2'(k);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lock_phase_counter.sv
// Free-running 0..NUM_KEYS*WINDOW-1 phase counter with window decode.
// Shared by the key sequencer and the locked FSMs so that both sides
// advance on the same negedge and can never drift apart.
module lock_phase_counter
    import lock_pkg::*;
#(
    parameter int NUM_KEYS = DEFAULT_NUM_KEYS,
    parameter int WINDOW   = DEFAULT_WINDOW,
    parameter int PH_W     = DEFAULT_PH_W
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PH_W-1:0] phase,
    output logic [1:0]      win,
    output logic            wrap
);

    localparam int LAST = NUM_KEYS * WINDOW - 1;

    assign wrap = (phase >= PH_W'(LAST));
    assign win  = phase_to_win(32'(phase), WINDOW, NUM_KEYS);

    // Phase advances every negedge and wraps back to 0 after the last window.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (wrap) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/key_window_sequencer.sv
// Key bank with serial provisioning. Keys are shifted into a shadow bank
// and committed to the active bank only at a phase wrap, so the consumer
// always sees a complete key schedule starting from phase 0.
module key_window_sequencer
    import lock_pkg::*;
#(
    parameter int KEY_W    = DEFAULT_KEY_W,
    parameter int NUM_KEYS = DEFAULT_NUM_KEYS,
    parameter int WINDOW   = DEFAULT_WINDOW,
    parameter int PH_W     = DEFAULT_PH_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic             load_bit,
    output logic             load_ready,
    output logic             load_err,
    input  logic             zeroize,
    output logic             bank_valid,
    output logic [KEY_W-1:0] key_out,
    output logic [PH_W-1:0]  phase,
    output logic [1:0]       win
);

    localparam int TOTAL = NUM_KEYS * KEY_W;
    localparam int CNT_W = $clog2(TOTAL + 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] bitcnt;
    logic [TOTAL-1:0] shadow;
    logic [TOTAL-1:0] active;
    logic             wrap;
    logic             accept;
    logic             last_bit;

    lock_phase_counter #(
        .NUM_KEYS (NUM_KEYS),
        .WINDOW   (WINDOW),
        .PH_W     (PH_W)
    ) u_phase (
        .clk   (clk),
        .rst   (rst),
        .phase (phase),
        .win   (win),
        .wrap  (wrap)
    );

    assign accept   = (state == LOAD) && load_valid && !load_start && !zeroize;
    assign last_bit = accept && (bitcnt == CNT_W'(TOTAL - 1));

    // State register.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: zeroize beats load_start, which beats normal flow.
    // NOTE: default assignment first so no path leaves next_state unassigned
    // and no latch is inferred.
    always_comb begin
        next_state = state;
        if (zeroize) begin
            next_state = IDLE;
        end else if (load_start) begin
            next_state = LOAD;
        end else begin
            case (state)
                LOAD:    if (last_bit) next_state = PEND;
                PEND:    if (wrap)     next_state = IDLE;
                default: next_state = state;
            endcase
        end
    end

    // Outputs decoded from state only.
    always_comb begin
        load_ready = (state == LOAD);
    end

    // Key banks, bit counter, commit and abort pulse.
    // NOTE: both key banks are reset and wiped explicitly; this storage holds
    // secrets, so it must never come up holding stale contents.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            bitcnt     <= '0;
            shadow     <= '0;
            active     <= '0;
            bank_valid <= 1'b0;
            load_err   <= 1'b0;
        end else if (zeroize) begin
            bitcnt     <= '0;
            shadow     <= '0;
            active     <= '0;
            bank_valid <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            load_err <= load_start && (state != IDLE);
            if (load_start) begin
                bitcnt <= '0;
                shadow <= '0;
            end else if (accept) begin
                shadow <= {load_bit, shadow[TOTAL-1:1]};
                bitcnt <= bitcnt + 1'b1;
            end else if (state == PEND && wrap) begin
                active     <= shadow;
                bank_valid <= 1'b1;
            end
        end
    end

    // Key bus: the active key for the current window, or all-zero when empty.
    always_comb begin
        key_out = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (bank_valid && win == 2'(k)) begin
                key_out = active[k*KEY_W +: KEY_W];
            end
        end
    end

endmodule

// File: tb/tb_key_window_sequencer.sv
// Self-checking bench for key_window_sequencer. A behavioural model holds the
// key schedule as an integer array and the in-flight load as a bit queue.
module tb_key_window_sequencer;

    localparam int KEY_W    = 10;
    localparam int NUM_KEYS = 3;
    localparam int WINDOW   = 6;
    localparam int PH_W     = 6;
    localparam int PER      = NUM_KEYS * WINDOW;
    localparam int TOTAL    = NUM_KEYS * KEY_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_start = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_bit = 1'b0;
    logic             zeroize = 1'b0;
    logic             load_ready;
    logic             load_err;
    logic             bank_valid;
    logic [KEY_W-1:0] key_out;
    logic [PH_W-1:0]  phase;
    logic [1:0]       win;

    int checks = 0;
    int errors = 0;

    key_window_sequencer #(
        .KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS), .WINDOW(WINDOW), .PH_W(PH_W)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_bit(load_bit), .load_ready(load_ready), .load_err(load_err),
        .zeroize(zeroize), .bank_valid(bank_valid), .key_out(key_out),
        .phase(phase), .win(win)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   m_phase;
    int   m_keys [NUM_KEYS];
    bit   m_valid;
    bit   m_loading;
    bit   m_pend;
    bit   m_err;
    bit   m_bits [$];

    const int KNOWN [3] = '{'h36B, 'h15F, 'h0EB};
    string VEC = "110101101111111010101101011100";

    task automatic model_reset();
        m_phase = 0; m_valid = 0; m_loading = 0; m_pend = 0; m_err = 0;
        foreach (m_keys[k]) m_keys[k] = 0;
        m_bits.delete();
    endtask

    task automatic model_step(input bit ls, input bit lv, input bit lb, input bit zz);
        m_err = 0;
        if (zz) begin
            foreach (m_keys[k]) m_keys[k] = 0;
            m_valid = 0; m_loading = 0; m_pend = 0;
            m_bits.delete();
        end else if (ls) begin
            m_err = m_loading || m_pend;
            m_loading = 1; m_pend = 0;
            m_bits.delete();
        end else if (m_loading) begin
            if (lv) begin
                m_bits.push_back(lb);
                if (m_bits.size() == TOTAL) begin
                    m_loading = 0; m_pend = 1;
                end
            end
        end else if (m_pend && m_phase == PER - 1) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                m_keys[k] = 0;
                for (int i = 0; i < KEY_W; i++)
                    if (m_bits[k*KEY_W + i]) m_keys[k] += (1 << i);
            end
            m_valid = 1; m_pend = 0;
        end
        m_phase = (m_phase + 1) % PER;
    endtask

    function automatic logic [20:0] exp_obs();
        int w;
        w = m_phase / WINDOW;
        return {6'(m_phase), 2'(w), m_valid ? 10'(m_keys[w]) : 10'd0,
                m_valid, m_loading, m_err};
    endfunction

    wire [20:0] obs = {phase, win, key_out, bank_valid, load_ready, load_err};

    // Drive inputs after a posedge, let the DUT and model take the negedge,
    // then return just after the following posedge for sampling.
    task automatic tick(input bit ls, input bit lv, input bit lb, input bit zz);
        load_start = ls; load_valid = lv; load_bit = lb; zeroize = zz;
        @(negedge clk);
        model_step(ls, lv, lb, zz);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        load_start = 0; load_valid = 0; load_bit = 0; zeroize = 0;
        model_reset();
        #1;
        checks++;
        if (obs !== 21'd0) begin
            errors++;
            $display("FAIL reset_immediate got %h want %h", obs, 21'd0);
        end
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs !== exp_obs() || phase !== 6'((i + 1) % PER)) begin
                errors++;
                $display("FAIL reset_run cyc=%0d got %h want %h", i, obs, exp_obs());
            end
        end
    endtask

    task automatic test_known_vector();
        tick(1, 0, 0, 0);
        for (int i = 0; i < TOTAL; i++) begin
            tick(0, 1, VEC[i] == "1", 0);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL vec_shift bit=%0d got %h want %h", i, obs, exp_obs());
            end
        end
        for (int i = 0; i < 2 * PER + 2; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL vec_commit cyc=%0d got %h want %h", i, obs, exp_obs());
            end
            if (m_valid) begin
                checks++;
                if (key_out !== 10'(KNOWN[m_phase / WINDOW])) begin
                    errors++;
                    $display("FAIL vec_key ph=%0d got %h want %h", m_phase, key_out,
                             10'(KNOWN[m_phase / WINDOW]));
                end
            end
        end
        checks++;
        if (bank_valid !== 1'b1) begin
            errors++;
            $display("FAIL vec_bank_valid got %b want 1", bank_valid);
        end
    endtask

    task automatic test_abort();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick(0, 1, 1'($urandom), 0);
        tick(1, 0, 0, 0);
        checks++;
        if (load_err !== 1'b1 || obs !== exp_obs()) begin
            errors++;
            $display("FAIL abort_pulse got %h want %h", obs, exp_obs());
        end
        for (int i = 0; i < TOTAL; i++) begin
            tick(0, 1, 1'($urandom), 0);
            checks++;
            if (obs !== exp_obs() || key_out !== 10'(KNOWN[m_phase / WINDOW])) begin
                errors++;
                $display("FAIL abort_keys_flow bit=%0d got %h want %h", i, obs, exp_obs());
            end
        end
        for (int i = 0; i < 2 * PER; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL abort_commit cyc=%0d got %h want %h", i, obs, exp_obs());
            end
        end
    endtask

    task automatic test_toggle_valid();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 2 * TOTAL + 10; i++) begin
            tick(0, i % 2 == 0, 1'($urandom), 0);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL toggle_load cyc=%0d got %h want %h", i, obs, exp_obs());
            end
        end
        for (int i = 0; i < 2 * PER; i++) begin
            tick(0, 1, 1'($urandom), 0);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL toggle_commit cyc=%0d got %h want %h", i, obs, exp_obs());
            end
        end
    endtask

    task automatic test_zeroize();
        for (int i = 0; i < PER && m_phase != 8; i++) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        checks++;
        if (key_out !== 10'd0 || bank_valid !== 1'b0 || phase !== 6'd9 ||
            obs !== exp_obs()) begin
            errors++;
            $display("FAIL zeroize got %h want %h", obs, exp_obs());
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL zeroize_after cyc=%0d got %h want %h", i, obs, exp_obs());
            end
        end
    endtask

    task automatic test_reset_midload();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 17; i++) tick(0, 1, 1'($urandom), 0);
        apply_reset();
        tick(1, 0, 0, 0);
        for (int i = 0; i < TOTAL; i++) tick(0, 1, VEC[i] == "1", 0);
        for (int i = 0; i < PER + 4; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL midload_reset cyc=%0d got %h want %h", i, obs, exp_obs());
            end
        end
        checks++;
        if (bank_valid !== 1'b1) begin
            errors++;
            $display("FAIL midload_commit got %b want 1", bank_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), $urandom_range(0, 149) == 0);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL random cyc=%0d got %h want %h", i, obs, exp_obs());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_known_vector();
        test_abort();
        test_toggle_valid();
        test_zeroize();
        test_reset_midload();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
